// File: rtl/ei_axi4_slave_mem.sv
// ei_axi4_slave_mem
//   AXI4 slave memory model. Independent write (AW/W/B) and read (AR/R)
//   engines, one outstanding burst per direction, word-addressed RAM of
//   MEM_DEPTH x DATA_WIDTH. FIXED and INCR bursts with byte strobes; WRAP
//   bursts when EI_AXI4_SLAVE_WRAP_EN is defined, otherwise WRAP is
//   answered as an illegal burst (SLVERR on every beat, no RAM access).
//
// Ports
//   aclk, areset           clock, asynchronous active-high reset
//   aw*/w*/b*              AXI4 write address, write data, write response
//   ar*/r*                 AXI4 read address, read data
//   write_state            current write FSM state (0 idle, 1 data, 2 resp)
//   read_state             current read FSM state (0 idle, 1 data)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Valid never depends on ready and is held until the transfer.
//
// DATA_WIDTH must be 32 or 64. The RAM is not reset.
module ei_axi4_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [1:0]              write_state,
    output logic                    read_state
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [2:0]            MAX_SIZE = 3'(ADDR_LSB);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH    = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // INCR step: align down to the beat size, then advance one beat.
    function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size);
        logic [ADDR_WIDTH-1:0] incr;
        incr = ONE << size;
        return (addr & ~(incr - ONE)) + incr;
    endfunction

`ifdef EI_AXI4_SLAVE_WRAP_EN
    // Legal WRAP spans are powers of two, so reaching the top of the span
    // shows up as the low address bits returning to zero.
    function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size,
                                                        input logic [7:0] len);
        logic [ADDR_WIDTH-1:0] span, nxt;
        span = (ADDR_WIDTH'(len) + ONE) << size;
        nxt  = step_addr(addr, size);
        if ((nxt & (span - ONE)) == '0) nxt = nxt - span;
        return nxt;
    endfunction
`endif

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> ADDR_LSB) < DEPTH;
    endfunction

    function automatic logic [IDX_W-1:0] ram_index(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'(addr >> ADDR_LSB);
    endfunction

    // Whole-burst errors are decided once, at the address handshake.
    logic aw_berr, ar_berr;
    always_comb begin
        aw_berr = (awsize > MAX_SIZE) || (awburst == 2'b11);
        ar_berr = (arsize > MAX_SIZE) || (arburst == 2'b11);
`ifdef EI_AXI4_SLAVE_WRAP_EN
        if (awburst == BURST_WRAP && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15})) aw_berr = 1'b1;
        if (arburst == BURST_WRAP && !(arlen inside {8'd1, 8'd3, 8'd7, 8'd15})) ar_berr = 1'b1;
`else
        if (awburst == BURST_WRAP) aw_berr = 1'b1;
        if (arburst == BURST_WRAP) ar_berr = 1'b1;
`endif
    end

    // ---------------- write engine ----------------
    logic [ADDR_WIDTH-1:0] wr_addr, wr_next;
    logic [7:0]            wr_len, wr_cnt;
    logic [2:0]            wr_size;
    logic [1:0]            wr_burst;
    logic                  wr_berr, wr_err;
    logic                  aw_fire, w_fire, b_fire, wr_last_beat, wr_beat_err, mem_we;

    assign aw_fire      = awvalid && awready;
    assign w_fire       = wvalid && wready;
    assign b_fire       = bvalid && bready;
    assign wr_last_beat = (wr_cnt == wr_len);
    assign wr_beat_err  = !in_range(wr_addr) || (wlast != wr_last_beat);
    assign mem_we       = w_fire && !wr_berr && in_range(wr_addr);
    assign write_state  = w_state;

    always_comb begin
        wr_next = wr_addr;
        if (wr_burst == BURST_INCR) wr_next = step_addr(wr_addr, wr_size);
`ifdef EI_AXI4_SLAVE_WRAP_EN
        else if (wr_burst == BURST_WRAP) wr_next = wrap_addr(wr_addr, wr_size, wr_len);
`endif
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_fire) w_next = W_DATA;
            W_DATA:  if (w_fire && wr_last_beat) w_next = W_RESP;
            W_RESP:  if (b_fire) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Ready/valid flops are loaded from the next state so they are glitch
    // free and all read 0 while reset is held.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
        end else begin
            w_state <= w_next;
            awready <= (w_next == W_IDLE);
            wready  <= (w_next == W_DATA);
            bvalid  <= (w_next == W_RESP);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_size  <= '0;
            wr_burst <= '0;
            wr_cnt   <= '0;
            wr_berr  <= 1'b0;
            wr_err   <= 1'b0;
            bid      <= '0;
            bresp    <= RESP_OKAY;
        end else begin
            if (aw_fire) begin
                wr_addr  <= awaddr;
                wr_len   <= awlen;
                wr_size  <= awsize;
                wr_burst <= awburst;
                wr_cnt   <= '0;
                wr_berr  <= aw_berr;
                wr_err   <= aw_berr;
                bid      <= awid;
            end
            if (w_fire) begin
                wr_cnt  <= wr_cnt + 8'd1;
                wr_addr <= wr_next;
                if (wr_beat_err) wr_err <= 1'b1;
                if (wr_last_beat) bresp <= (wr_err || wr_beat_err) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb[b]) mem[ram_index(wr_addr)][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    logic [ADDR_WIDTH-1:0] rd_addr, rd_next, rd_load_addr;
    logic [7:0]            rd_len, rd_cnt;
    logic [2:0]            rd_size;
    logic [1:0]            rd_burst, rd_load_resp;
    logic                  rd_berr, rd_load_berr, ar_fire, r_fire;
    logic [DATA_WIDTH-1:0] rd_load_data;

    assign ar_fire    = arvalid && arready;
    assign r_fire     = rvalid && rready;
    assign read_state = r_state;

    always_comb begin
        rd_next = rd_addr;
        if (rd_burst == BURST_INCR) rd_next = step_addr(rd_addr, rd_size);
`ifdef EI_AXI4_SLAVE_WRAP_EN
        else if (rd_burst == BURST_WRAP) rd_next = wrap_addr(rd_addr, rd_size, rd_len);
`endif
    end

    // Beat 0 is fetched from araddr at the AR handshake; later beats from
    // the advanced address at each R handshake. The fetch sees the RAM
    // before any same-edge write, so a colliding read returns old data.
    always_comb begin
        rd_load_addr = ar_fire ? araddr : rd_next;
        rd_load_berr = ar_fire ? ar_berr : rd_berr;
        rd_load_data = '0;
        rd_load_resp = RESP_SLVERR;
        if (!rd_load_berr && in_range(rd_load_addr)) begin
            rd_load_data = mem[ram_index(rd_load_addr)];
            rd_load_resp = RESP_OKAY;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire) r_next = R_DATA;
            R_DATA:  if (r_fire && rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
        end else begin
            r_state <= r_next;
            arready <= (r_next == R_IDLE);
            rvalid  <= (r_next == R_DATA);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_size  <= '0;
            rd_burst <= '0;
            rd_cnt   <= '0;
            rd_berr  <= 1'b0;
            rid      <= '0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
            rlast    <= 1'b0;
        end else if (ar_fire) begin
            rd_addr  <= araddr;
            rd_len   <= arlen;
            rd_size  <= arsize;
            rd_burst <= arburst;
            rd_cnt   <= '0;
            rd_berr  <= ar_berr;
            rid      <= arid;
            rdata    <= rd_load_data;
            rresp    <= rd_load_resp;
            rlast    <= (arlen == 8'd0);
        end else if (r_fire) begin
            if (rlast) begin
                rlast <= 1'b0;
            end else begin
                rd_cnt  <= rd_cnt + 8'd1;
                rd_addr <= rd_next;
                rdata   <= rd_load_data;
                rresp   <= rd_load_resp;
                rlast   <= ((rd_cnt + 8'd1) == rd_len);
            end
        end
    end
endmodule

// File: doc/ei_axi4_slave_mem.md
# ei_axi4_slave_mem

AXI4 slave memory model: the synthesizable device-under-test that connects to the VIP's AXI4 interface and answers the master agent's traffic. It has independent write (AW/W/B) and read (AR/R) engines, one outstanding burst per direction, and a word-addressed internal RAM. It supports FIXED, INCR and (optionally) WRAP bursts with byte strobes. Every VIP test sequence runs against this memory.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; must be 32 or 64
- ID_WIDTH, 4, transaction ID width
- MEM_DEPTH, 1024, RAM depth in DATA_WIDTH words
- aclk  in  1  clock; all logic on the rising edge
- areset  in  1  asynchronous, active-high reset
- awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address channel
- awvalid in 1, awready out 1
- wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data channel
- wvalid in 1, wready out 1
- bid/bresp  out  ID_WIDTH/2  write response
- bvalid out 1, bready in 1
- arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address channel
- arvalid in 1, arready out 1
- rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data channel
- rvalid out 1, rready in 1

## Operation
- Write FSM has three states: W_IDLE (awready=1), then W_DATA (wready=1), then W_RESP (bvalid=1), then back to W_IDLE on bready.
- Read FSM has two states: R_IDLE (arready=1), then R_DATA (rvalid=1). After the beat with rlast and rready, it returns to R_IDLE.
- A burst has awlen+1 or arlen+1 beats. The beat counter is 8 bits.
- Beat address:
  - FIXED: constant.
  - INCR: addr + (1<<size). The address is aligned down to size after the first beat.
  - WRAP: same increment, wrapping at the boundary (len+1)*(1<<size).
- RAM index = beat address >> log2(DATA_WIDTH/8), taken modulo nothing.
- SLVERR conditions:
  - Index ≥ MEM_DEPTH: SLVERR for that beat. The write is suppressed; the read returns 0.
  - size > log2(DATA_WIDTH/8): SLVERR for the whole burst, no RAM access.
  - Burst type 2'b11: SLVERR for the whole burst, no RAM access.
  - WRAP with len not in {1,3,7,15}: SLVERR for the whole burst, no RAM access.
- bresp: OKAY unless any beat erred or the wlast check failed, in which case SLVERR.
- wlast check:
  - The burst always ends on the counted final beat.
  - wlast early, or missing on the final beat, gives SLVERR.
  - Extra W beats after the burst are not accepted (wready=0).
- Writes honour wstrb per byte. rresp is per beat.
- rlast is high exactly on beat arlen.
- bid and rid echo the captured IDs.
- The write and read engines run concurrently. If a write and a read-data load hit the same word in the same cycle, the read returns the old value.
- The RAM is not reset. Contents are undefined until written.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, bresp=0, bid=0, arready=0, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0.
- awready and arready are registered. They rise on the first clock edge after areset deasserts.
- Reset asserted mid-burst aborts both FSMs to idle with outputs at reset values. No B or R response is issued for the aborted burst.
- AW handshake at edge N: awready=0 and wready=1 from N+1.
- W final-beat handshake at edge M: wready=0 and bvalid=1 from M+1. The RAM write for each beat commits at that beat's handshake edge.
- B handshake: awready=1 the next cycle. Minimum write turnaround is 1 idle cycle between bursts.
- AR handshake at edge N: rvalid=1 with beat-0 data from N+1.
- rdata is registered. It is reloaded on each R handshake and held stable while rvalid && !rready.
- Throughput is one beat per cycle on both W and R under continuous valid/ready.
- Valid signals never drop without their handshake.

## Configuration
- EI_AXI4_SLAVE_WRAP_EN defined: WRAP bursts are supported as described above.
- Not defined: WRAP bursts are treated as illegal (whole-burst SLVERR, no RAM access, full beat count still consumed/returned). The wrap-boundary logic is not compiled.

## Test plan
- INCR write of 4 beats at 0x10 (DATA_WIDTH=32) with data 0xA0..0xA3 and wstrb=0xF, then an INCR read of 4 beats at 0x10. Required: bresp=OKAY; read returns 0xA0..0xA3, rresp=OKAY, rlast on beat 3, rid equals arid.
- Write 0xFFFFFFFF at 0x0, then write 0x00000000 at 0x0 with wstrb=0x5, then read 0x0. Required: read returns 0xFF00FF00.
- With EI_AXI4_SLAVE_WRAP_EN defined: WRAP read of len=3 at 0x08 after words 0x0..0xC are written 1..4. Required: read returns 3,4,1,2. Without the macro: rresp=SLVERR on all 4 beats.
- Write of 2 beats at address MEM_DEPTH*4-4. Required: bresp=SLVERR; word MEM_DEPTH-1 is written. Write of 2 beats with wlast on beat 0. Required: bresp=SLVERR.
- Read of 8 beats with rready toggling 1/0 each cycle. Required: rdata stable during stalls; total of 8 beats. Assert areset during beat 3. Required: rvalid=0 immediately; arready=1 one edge after release.
